if_fetch_buf: RTL

Parametrised instruction-fetch front end that supersedes the bare pc_reg + if_id pair in the openmips pipeline. It generates the PC, issues requests to an instruction ROM with fixed read latency ROM_LAT, and buffers the returned instructions with their PCs in a DEPTH-entry FIFO. The ID stage consumes from the FIFO under a stall signal. A branch flush redirects the PC and discards all buffered and in-flight fetches.

---
 rtl/if_fetch_buf.sv | 131 +++++++++++++
 1 files changed

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: PC generator, fixed-latency ROM request tracking
// and a DEPTH-entry instruction/PC FIFO feeding the ID stage.
module if_fetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                ROM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic [ADDR_W-1:0]            new_pc_i,
    output logic                         rom_ce_o,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [DATA_W-1:0]            rom_data_i,
    output logic                         id_valid_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [DATA_W-1:0]            id_inst_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ROM_LAT-1:0] tag_v;
    logic [ADDR_W-1:0] tag_pc [ROM_LAT];
    logic [ADDR_W-1:0] mem_pc [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW:0]       occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    // Slots already promised to in-flight fetches count as occupied, so a
    // returning fetch always finds room even if ID stalls meanwhile.
    assign occupancy  = {1'b0, count} + {1'b0, inflight};
    assign issue      = !rst && !flush_i && (occupancy < (CW+1)'(DEPTH));
    assign head_valid = !rst && (count != '0);
    assign push       = !rst && !flush_i && tag_v[ROM_LAT-1];
    assign pop        = head_valid && !stall_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush_i) begin
            pc_q <= new_pc_i;
        end else if (issue) begin
            pc_q <= pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_pc[0] <= pc_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_pc[i] <= tag_pc[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= tag_pc[ROM_LAT-1];
            mem_inst[wr_ptr] <= rom_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rom_ce_o   = issue;
    assign rom_addr_o = issue ? pc_q : '0;
    assign id_valid_o = head_valid;
    assign id_pc_o    = head_valid ? mem_pc[rd_ptr] : '0;
    assign id_inst_o  = head_valid ? mem_inst[rd_ptr] : '0;
    assign fifo_cnt_o = rst ? '0 : count;

    a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
        occupancy <= (CW+1)'(DEPTH));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(DEPTH)));

endmodule
